sync_bit_arbiter: RTL and testbench
===================================

# sync_bit_arbiter

Source-domain controller that shares one toggle-handshake synchronizer bit among `NREQ` requesters. It arbitrates round-robin, drives the synchronizer's enable and data inputs with a single toggle per transaction, and waits for the returning acknowledge bit before issuing a completion pulse. It sits in the source clock domain between requesting logic and a two-register bit synchronizer whose far-end value is synchronized back as `ackIn`.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `init`, 1'b0: reset value of `sD_IN`. Must equal the synchronizer's `init`.
- `TIMEOUT`, 255: cycles spent in WAIT before abort, 1..65535. Used only when the timeout is compiled in.

Ports:
- `CLK`  in  1  block clock; the synchronizer's source clock.
- `RST`  in  1  reset; synchronous and active-high.
- `req`  in  NREQ  request level per requester. Held high until that requester's `done` pulse.
- `grant`  out  NREQ  one-hot owner of the current transaction; all zeros in IDLE.
- `done`  out  NREQ  one-cycle completion pulse to the owner.
- `sEN`  out  1  synchronizer enable; one-cycle pulse per transaction.
- `sD_IN`  out  1  synchronizer data; toggles once per transaction.
- `ackIn`  in  1  synchronized copy of the far-end bit. Treated as already synchronized to `CLK`.
- `busy`  out  1  high whenever the state is not IDLE.
- `timeout`  out  1  one-cycle abort pulse; present only with the timeout compiled in.

## Operation
- **State machine:** three states, IDLE, WAIT and DONE. All outputs are registered.
- **IDLE:**
  - If any `req` bit is high, pick the winner: the first set bit scanning upward from `ptr` and wrapping.
  - On the next clock: `grant` is the one-hot winner, `sEN`=1, `sD_IN`=~`sD_IN`, and state moves to WAIT.
- **WAIT:**
  - `sEN`=0.
  - When `ackIn`==`sD_IN`: `done[winner]`=1 next cycle, `ptr`=(winner+1) mod `NREQ`, state moves to DONE.
  - `req` changes are ignored.
- **DONE:**
  - `done` is high for exactly this cycle and `grant` is still held.
  - `req` is not sampled, so the same requester cannot be re-granted before it drops `req`.
  - Next clock: `grant`=0, `done`=0, state moves to IDLE.
- **Round-robin:** `ptr` has width ceil(log2 NREQ) and wraps from `NREQ`-1 to 0. After a grant, the winner has the lowest priority.
- **Reset:** state=IDLE, `ptr`=0, `grant`=0, `done`=0, `sEN`=0, `sD_IN`=`init`, `busy`=0, `timeout`=0, and the timeout counter is 0.
- **Reset mid-transaction:** the transaction is dropped with no `done` and no `timeout`. Arbitration in IDLE starts in the first cycle after `RST` falls.
- **Early ack:** `ackIn` already equal to the new `sD_IN` in the first WAIT cycle completes immediately. This is legal.
- **Requester drops `req` during WAIT:** the transaction still completes and `done` still pulses.

## Timing
- **Latency:** request seen in IDLE at cycle t:
  - `sEN`/`grant` at t+1.
  - Earliest `done` at t+2, when `ackIn` matches in the first WAIT cycle.
  - With a 2-flop synchronizer on each direction, a typical `done` lands at t+6..t+8.
- **Throughput:** at most one transaction per 3 cycles, because IDLE→WAIT→DONE is always traversed.
- **`busy`:** high from t+1 through the DONE cycle inclusive.
- **`sD_IN`:** changes only in the same cycle `sEN` is high, and is otherwise stable.

## Configuration
- **`SYNC_BIT_ARB_TIMEOUT_EN` defined:**
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT` without a match, the next cycle has `timeout`=1, `grant`=0, no `done`, and state IDLE.
  - `ptr` still advances past the aborted winner.
  - `sD_IN` is not reverted. A late ack is absorbed, because the next transaction compares against the new toggle value.
- **Macro not defined:** no counter and no `timeout` port. WAIT waits indefinitely.

## Test plan
- **Reset values:** assert `RST` 3 cycles, then release. Required: `grant`=0, `done`=0, `sEN`=0, `sD_IN`=0, `busy`=0.
- **Single request:** `req`=4'b0010 with `ackIn` looped back through 2 flops. Required: `grant`=0010 and a one-cycle `sEN` pulse one cycle after `req`, `sD_IN` 0→1, then a single `done`=0010 pulse, and `busy` low after DONE.
- **Round-robin fairness:** `req`=4'b1111 held continuously. Required grant order 0001, 0010, 0100, 1000, 0001, with `sD_IN` toggling on each grant.
- **Reset mid-transaction:** `RST` pulsed high for 1 cycle while in WAIT. Required: no `done`, `sD_IN`=`init`, and the next `req` is granted normally.
- **Timeout:** with `SYNC_BIT_ARB_TIMEOUT_EN` defined, `TIMEOUT`=8, `ackIn` stuck at 0, `req`=0001. Required: `timeout` pulses 9 cycles after `sEN`, no `done`, and the next request from requester 1 is served first.
- **Requester drops `req` in WAIT:** `req` falls while the transaction is in WAIT. Required: `done` still pulses for that requester.

Source files
------------

// File: rtl/sync_bit_arbiter.sv
// rtl/sync_bit_arbiter.sv - round-robin owner of a shared toggle-handshake synchronizer bit
//
// Purpose: arbitrates NREQ requesters for one two-register bit synchronizer.
//   Each transaction toggles sD_IN once (with a one-cycle sEN pulse), then
//   waits for the synchronized far-end copy (ackIn) to match before pulsing
//   done to the owner.
// Optional feature macro: SYNC_BIT_ARB_TIMEOUT_EN adds a WAIT-state abort
//   counter and the timeout output.
// Ports:
//   CLK     in   block clock (synchronizer source clock)
//   RST     in   synchronous active-high reset
//   req     in   [NREQ] request levels, held until that requester's done
//   grant   out  [NREQ] one-hot owner of current transaction, 0 in IDLE
//   done    out  [NREQ] one-cycle completion pulse to the owner
//   sEN     out  synchronizer enable, one pulse per transaction
//   sD_IN   out  synchronizer data, toggles once per transaction
//   ackIn   in   synchronized far-end bit
//   busy    out  high whenever not IDLE
//   timeout out  one-cycle abort pulse (only with SYNC_BIT_ARB_TIMEOUT_EN)
module sync_bit_arbiter #(
    parameter int   NREQ    = 4,
    parameter logic init    = 1'b0,
    parameter int   TIMEOUT = 255
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] done,
    output logic            sEN,
    output logic            sD_IN,
    input  logic            ackIn,
    output logic            busy
`ifdef SYNC_BIT_ARB_TIMEOUT_EN
    ,
    output logic            timeout
`endif
);

    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("sync_bit_arbiter: NREQ or TIMEOUT out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   win_q, win_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            sen_q, sen_d;
    logic            sd_in_q, sd_in_d;
    logic            busy_q, busy_d;
`ifdef SYNC_BIT_ARB_TIMEOUT_EN
    logic [15:0]     cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
`endif

    logic            found;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   ptr_next;
    logic [NREQ-1:0] pick_onehot;

    // First set request scanning upward from ptr, wrapping at NREQ-1.
    always_comb begin : pick
        int            idx;
        logic [PW-1:0] idx_v;
        found    = 1'b0;
        pick_idx = '0;
        idx      = 0;
        idx_v    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_v = PW'(idx);
            if (!found && req[idx_v]) begin
                found    = 1'b1;
                pick_idx = idx_v;
            end
        end
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
    end

    // The finished (or aborted) winner drops to lowest priority.
    assign ptr_next = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        grant_d = grant_q;
        done_d  = '0;
        sen_d   = 1'b0;
        sd_in_d = sd_in_q;
`ifdef SYNC_BIT_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (found) begin
                    win_d   = pick_idx;
                    grant_d = pick_onehot;
                    sen_d   = 1'b1;
                    sd_in_d = ~sd_in_q;
                    state_d = S_WAIT;
`ifdef SYNC_BIT_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                // sd_in_q already holds the toggled value, so a match means
                // the far end has seen this transaction's toggle.
                if (ackIn == sd_in_q) begin
                    done_d  = grant_q;
                    ptr_d   = ptr_next;
                    state_d = S_DONE;
                end
`ifdef SYNC_BIT_ARB_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT)) begin
                    // sD_IN is left toggled; a late ack is absorbed because
                    // the next transaction compares against its own toggle.
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    ptr_d     = ptr_next;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            S_DONE: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            sen_q     <= 1'b0;
            sd_in_q   <= init;
            busy_q    <= 1'b0;
`ifdef SYNC_BIT_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            sen_q     <= sen_d;
            sd_in_q   <= sd_in_d;
            busy_q    <= busy_d;
`ifdef SYNC_BIT_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign sEN   = sen_q;
    assign sD_IN = sd_in_q;
    assign busy  = busy_q;
`ifdef SYNC_BIT_ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_sync_bit_arbiter.sv
// tb/tb_sync_bit_arbiter.sv - directed self-checking bench for sync_bit_arbiter
module tb_sync_bit_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] done;
    logic       sEN;
    logic       sD_IN;
    logic       ackIn;
    logic       busy;
`ifdef SYNC_BIT_ARB_TIMEOUT_EN
    logic       timeout;
`endif

    logic ff1, ff2;
    logic loop_en   = 1'b1;
    logic ack_force = 1'b0;

    int checks   = 0;
    int failures = 0;

    sync_bit_arbiter #(
        .NREQ(4),
        .init(1'b0),
        .TIMEOUT(8)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .req(req),
        .grant(grant),
        .done(done),
        .sEN(sEN),
        .sD_IN(sD_IN),
        .ackIn(ackIn),
        .busy(busy)
`ifdef SYNC_BIT_ARB_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    always #5 CLK = ~CLK;

    // Two-flop return path standing in for the far-end synchronizer.
    always @(posedge CLK) begin
        if (RST) begin
            ff1 <= 1'b0;
            ff2 <= 1'b0;
        end else begin
            ff1 <= sD_IN;
            ff2 <= ff1;
        end
    end
    assign ackIn = loop_en ? ff2 : ack_force;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        req = 4'b0000;
        repeat (3) step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        loop_en = 1'b1;
        apply_reset();
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b want=0000", grant); end
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL reset_done got=%b want=0000", done); end
        checks++; if (sEN !== 1'b0) begin failures++; $display("FAIL reset_sen got=%b want=0", sEN); end
        checks++; if (sD_IN !== 1'b0) begin failures++; $display("FAIL reset_sd_in got=%b want=0", sD_IN); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
`ifdef SYNC_BIT_ARB_TIMEOUT_EN
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b want=0", timeout); end
`endif
    endtask

    task automatic test_single_request();
        int n;
        req = 4'b0010;
        step();
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL single_grant got=%b want=0010", grant); end
        checks++; if (sEN !== 1'b1) begin failures++; $display("FAIL single_sen got=%b want=1", sEN); end
        checks++; if (sD_IN !== 1'b1) begin failures++; $display("FAIL single_sd_in got=%b want=1", sD_IN); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b want=1", busy); end
        step();
        checks++; if (sEN !== 1'b0) begin failures++; $display("FAIL single_sen_pulse got=%b want=0", sEN); end
        n = 0;
        while (done === 4'b0000 && n < 20) begin
            step();
            n++;
        end
        checks++; if (done !== 4'b0010) begin failures++; $display("FAIL single_done got=%b want=0010", done); end
        checks++; if (n !== 2) begin failures++; $display("FAIL single_done_latency got=%0d want=2", n); end
        checks++; if (busy !== 1'b1 || grant !== 4'b0010) begin failures++; $display("FAIL single_done_cycle busy=%b grant=%b want busy=1 grant=0010", busy, grant); end
        req = 4'b0000;
        step();
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL single_done_width got=%b want=0000", done); end
        checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin failures++; $display("FAIL single_idle busy=%b grant=%b want busy=0 grant=0000", busy, grant); end
    endtask

    task automatic test_round_robin();
        logic [3:0] rr_exp [0:4];
        logic       exp_sd;
        int         n;
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001;
        loop_en = 1'b1;
        apply_reset();
        exp_sd = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (sEN !== 1'b1 && n < 20) begin
                step();
                n++;
            end
            exp_sd = ~exp_sd;
            checks++; if (sEN !== 1'b1) begin failures++; $display("FAIL rr_sen_%0d got=%b want=1", k, sEN); end
            checks++; if (grant !== rr_exp[k]) begin failures++; $display("FAIL rr_grant_%0d got=%b want=%b", k, grant, rr_exp[k]); end
            checks++; if (sD_IN !== exp_sd) begin failures++; $display("FAIL rr_sd_in_%0d got=%b want=%b", k, sD_IN, exp_sd); end
            step();
        end
        req = 4'b0000;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_drain busy=%b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        req = 4'b0001;
        step();
        checks++; if (sEN !== 1'b1) begin failures++; $display("FAIL mid_sen got=%b want=1", sEN); end
        RST = 1'b1;
        req = 4'b0000;
        step();
        RST = 1'b0;
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL mid_done got=%b want=0000", done); end
        checks++; if (sD_IN !== 1'b0) begin failures++; $display("FAIL mid_sd_in got=%b want=0", sD_IN); end
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL mid_idle grant=%b busy=%b want 0000/0", grant, busy); end
        req = 4'b0100;
        step();
        checks++; if (grant !== 4'b0100 || sEN !== 1'b1) begin failures++; $display("FAIL mid_regrant grant=%b sen=%b want 0100/1", grant, sEN); end
        n = 0;
        while (done === 4'b0000 && n < 20) begin
            step();
            n++;
        end
        checks++; if (done !== 4'b0100) begin failures++; $display("FAIL mid_regrant_done got=%b want=0100", done); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_drop_in_wait();
        int n;
        req = 4'b1000;
        step();
        checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL drop_grant got=%b want=1000", grant); end
        step();
        req = 4'b0000;
        n = 0;
        while (done === 4'b0000 && n < 20) begin
            step();
            n++;
        end
        checks++; if (done !== 4'b1000) begin failures++; $display("FAIL drop_done got=%b want=1000", done); end
        step();
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL drop_done_width got=%b want=0000", done); end
    endtask

    task automatic test_early_ack();
        loop_en   = 1'b0;
        ack_force = 1'b1;
        apply_reset();
        req = 4'b0001;
        step();
        checks++; if (sEN !== 1'b1 || sD_IN !== 1'b1) begin failures++; $display("FAIL early_sen sen=%b sd_in=%b want 1/1", sEN, sD_IN); end
        step();
        checks++; if (done !== 4'b0001) begin failures++; $display("FAIL early_done got=%b want=0001", done); end
        req = 4'b0000;
        step();
        checks++; if (done !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL early_idle done=%b busy=%b want 0000/0", done, busy); end
        loop_en = 1'b1;
    endtask

`ifdef SYNC_BIT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        loop_en   = 1'b0;
        ack_force = 1'b0;
        apply_reset();
        req = 4'b0001;
        step();
        checks++; if (sEN !== 1'b1) begin failures++; $display("FAIL to_sen got=%b want=1", sEN); end
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k < 9) begin
                checks++; if (timeout !== 1'b0 || done !== 4'b0000) begin failures++; $display("FAIL to_early_%0d timeout=%b done=%b want 0/0000", k, timeout, done); end
            end else begin
                checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_pulse got=%b want=1", timeout); end
                checks++; if (grant !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000) begin failures++; $display("FAIL to_abort grant=%b busy=%b done=%b want 0000/0/0000", grant, busy, done); end
            end
        end
        req = 4'b0011;
        step();
        checks++; if (grant !== 4'b0010 || timeout !== 1'b0) begin failures++; $display("FAIL to_next_grant grant=%b timeout=%b want 0010/0", grant, timeout); end
        step();
        checks++; if (done !== 4'b0010) begin failures++; $display("FAIL to_next_done got=%b want=0010", done); end
        req = 4'b0000;
        step();
        loop_en = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        req = 4'b0000;
        test_reset();
        test_single_request();
        test_round_robin();
        test_reset_mid();
        test_drop_in_wait();
        test_early_ack();
`ifdef SYNC_BIT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
